// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory-access stage: RV32I opcodes, func3 codes
// and the LSU state encoding.
package mem_stage_lsu_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  function automatic logic is_mem_op(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

endpackage

// File: rtl/mem_stage_lsu_lane_align.sv
// Byte-lane steering for the LSU: store strobes/replicated data and the
// misalign/illegal-func3 check on the incoming op, load extract/extend on the
// returned word.
module mem_stage_lsu_lane_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  func3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  output logic        misalign_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_func3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted;

  // Incoming op: legality check and store lane generation.
  always_comb begin
    misalign_o = 1'b0;
    wstrb_o    = 4'b0000;
    wdata_o    = 32'h0000_0000;
    if (opcode_i == OPC_LOAD) begin
      case (func3_i)
        F3_LB, F3_LBU: misalign_o = 1'b0;
        F3_LH, F3_LHU: misalign_o = addr_lo_i[0];
        F3_LW:         misalign_o = (addr_lo_i != 2'b00);
        default:       misalign_o = 1'b1;
      endcase
    end else if (opcode_i == OPC_STORE) begin
      case (func3_i)
        F3_SB: begin
          wstrb_o = 4'b0001 << addr_lo_i;
          wdata_o = {4{store_data_i[7:0]}};
        end
        F3_SH: begin
          misalign_o = addr_lo_i[0];
          wstrb_o    = 4'b0011 << addr_lo_i;
          wdata_o    = {2{store_data_i[15:0]}};
        end
        F3_SW: begin
          misalign_o = (addr_lo_i != 2'b00);
          wstrb_o    = 4'b1111;
          wdata_o    = store_data_i;
        end
        default: misalign_o = 1'b1;
      endcase
    end else begin
      misalign_o = 1'b0;
    end
  end

  // Returned word: move the addressed lane to bit 0, then extend.
  always_comb begin
    shifted = rdata_i >> {ld_addr_lo_i, 3'b000};
    case (ld_func3_i)
      F3_LB:   ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  ld_data_o = {24'h00_0000, shifted[7:0]};
      F3_LHU:  ld_data_o = {16'h0000, shifted[15:0]};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-access stage: one op in flight, RV32I loads/stores over a
// req/gnt/rvalid data port with an access timeout, pass-through otherwise.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd_in,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_wstrb,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            exc_misalign,
  output logic            bus_err
);

  // Expiry is judged on the post-increment count so RESP lands TIMEOUT cycles after accept.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 2);

  lsu_state_e      state_q, state_d;
  logic [6:0]      opc_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q;
  logic [4:0]      rd_q;
  logic [3:0]      wstrb_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] result_q;
  logic            wbwe_q;
  logic            exc_q;
  logic            berr_q;
  logic [7:0]      cnt_q;

  logic            accept;
  logic            expire;
  logic            misalign;
  logic [3:0]      wstrb_new;
  logic [XLEN-1:0] wdata_new;
  logic [XLEN-1:0] ld_data;

  assign accept = req_valid && (state_q == ST_IDLE);
  assign expire = (cnt_q >= CNT_LAST);

  mem_stage_lsu_lane_align u_lane (
    .opcode_i     (opcode),
    .func3_i      (func3),
    .addr_lo_i    (alu_out[1:0]),
    .store_data_i (store_data),
    .misalign_o   (misalign),
    .wstrb_o      (wstrb_new),
    .wdata_o      (wdata_new),
    .ld_func3_i   (f3_q),
    .ld_addr_lo_i (addr_q[1:0]),
    .rdata_i      (dmem_rdata),
    .ld_data_o    (ld_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a gnt/rvalid in the expiry cycle takes precedence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (is_mem_op(opcode) && !misalign) ? ST_REQ : ST_RESP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dmem_gnt) begin
          state_d = (opc_q == OPC_STORE) ? ST_RESP : ST_WAIT;
        end else if (expire) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (dmem_rvalid || expire) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Op capture, timeout counter, load result and completion flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_q    <= 7'd0;
      f3_q     <= 3'd0;
      addr_q   <= {XLEN{1'b0}};
      rd_q     <= 5'd0;
      wstrb_q  <= 4'd0;
      wdata_q  <= {XLEN{1'b0}};
      result_q <= {XLEN{1'b0}};
      wbwe_q   <= 1'b0;
      exc_q    <= 1'b0;
      berr_q   <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            opc_q    <= opcode;
            f3_q     <= func3;
            addr_q   <= alu_out;
            rd_q     <= rd_in;
            wstrb_q  <= wstrb_new;
            wdata_q  <= wdata_new;
            result_q <= is_mem_op(opcode) ? {XLEN{1'b0}} : alu_out;
            wbwe_q   <= (rd_in != 5'd0) && (opcode != OPC_BRANCH) &&
                        (opcode != OPC_STORE) && !(is_mem_op(opcode) && misalign);
            exc_q    <= is_mem_op(opcode) && misalign;
            berr_q   <= 1'b0;
            cnt_q    <= 8'd0;
          end
        end
        ST_REQ, ST_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if ((state_q == ST_WAIT) && dmem_rvalid) begin
            result_q <= ld_data;
          end else if (!((state_q == ST_REQ) && dmem_gnt) && expire) begin
            berr_q <= 1'b1;
            wbwe_q <= 1'b0;
          end
        end
        ST_RESP: begin
          exc_q  <= 1'b0;
          berr_q <= 1'b0;
        end
        default: cnt_q <= 8'd0;
      endcase
    end
  end

  // Outputs decoded from the state register and captured op.
  always_comb begin
    req_ready    = (state_q == ST_IDLE);
    dmem_req     = (state_q == ST_REQ);
    dmem_we      = dmem_req && (opc_q == OPC_STORE);
    dmem_addr    = dmem_req ? {addr_q[XLEN-1:2], 2'b00} : {XLEN{1'b0}};
    dmem_wstrb   = dmem_req ? wstrb_q : 4'b0000;
    dmem_wdata   = dmem_req ? wdata_q : {XLEN{1'b0}};
    wb_valid     = (state_q == ST_RESP);
    wb_we        = wb_valid && wbwe_q;
    wb_rd        = wb_valid ? rd_q : 5'd0;
    wb_data      = wb_valid ? result_q : {XLEN{1'b0}};
    exc_misalign = wb_valid && exc_q;
    bus_err      = wb_valid && berr_q;
  end

endmodule
